// File: rtl/mbscore_rf_bank_if.sv
// Register-bank bus: two GPR read ports, ALU and memory write ports, SPR
// access and interrupt entry/return. The master drives the requests.
interface mbscore_rf_bank_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SPR_ADDR_WIDTH = 3
);
  logic [REG_ADDR_WIDTH-1:0] rs_addr, rt_addr;
  logic [DATA_WIDTH-1:0]     rs_out, rt_out;
  logic                      wa_en, wa_lui, wa_link;
  logic [REG_ADDR_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0]     wa_data, pc_in;
  logic                      wm_en;
  logic [REG_ADDR_WIDTH-1:0] wm_addr;
  logic [DATA_WIDTH-1:0]     wm_data;
  logic                      spr_we;
  logic [SPR_ADDR_WIDTH-1:0] spr_addr;
  logic [DATA_WIDTH-1:0]     spr_wdata, spr_wmask, spr_out;
  logic                      set_intr, eret, int_en_n;

  modport master (
    output rs_addr, rt_addr, wa_en, wa_addr, wa_data, wa_lui, wa_link, pc_in,
           wm_en, wm_addr, wm_data, spr_we, spr_addr, spr_wdata, spr_wmask,
           set_intr, eret,
    input  rs_out, rt_out, spr_out, int_en_n
  );

  modport slave (
    input  rs_addr, rt_addr, wa_en, wa_addr, wa_data, wa_lui, wa_link, pc_in,
           wm_en, wm_addr, wm_data, spr_we, spr_addr, spr_wdata, spr_wmask,
           set_intr, eret,
    output rs_out, rt_out, spr_out, int_en_n
  );
endinterface

// File: rtl/mbscore_rf_bank.sv
// GPR bank (2 registered read ports with write forwarding, ALU + memory write
// ports) and SPR bank holding EPC (spr[0]) and STATUS (spr[1]).
module mbscore_rf_bank #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SPR_ADDR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  mbscore_rf_bank_if.slave     bus
);
  localparam int NREG = 2**REG_ADDR_WIDTH;
  localparam int NSPR = 2**SPR_ADDR_WIDTH;
  localparam logic [SPR_ADDR_WIDTH-1:0] EPC    = SPR_ADDR_WIDTH'(0);
  localparam logic [SPR_ADDR_WIDTH-1:0] STATUS = SPR_ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0]     gpr [NREG];
  logic [DATA_WIDTH-1:0]     spr [NSPR];
  logic [DATA_WIDTH-1:0]     rs_q, rt_q;
  logic [REG_ADDR_WIDTH-1:0] wa_dst;
  logic [DATA_WIDTH-1:0]     wa_val, spr_masked;

  // Link overrides both the destination and the lui formatting.
  always_comb begin
    wa_dst = bus.wa_link ? '1 : bus.wa_addr;
    if (bus.wa_link)     wa_val = bus.pc_in + DATA_WIDTH'(4);
    else if (bus.wa_lui) wa_val = bus.wa_data << (DATA_WIDTH-16);
    else                 wa_val = bus.wa_data;
  end

  // Forwarding order mirrors commit order: memory write beats ALU write.
  function automatic logic [DATA_WIDTH-1:0] rd_fwd(input logic [REG_ADDR_WIDTH-1:0] a);
    if (a == '0)                          return '0;
    if (bus.wm_en && bus.wm_addr == a)    return bus.wm_data;
    if (bus.wa_en && wa_dst == a)         return wa_val;
    return gpr[a];
  endfunction

  assign spr_masked   = (bus.spr_wdata & bus.spr_wmask) | (bus.spr_out & ~bus.spr_wmask);
  assign bus.spr_out  = spr[bus.spr_addr];
  assign bus.int_en_n = spr[STATUS][0];
  assign bus.rs_out   = rs_q;
  assign bus.rt_out   = rt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gpr  <= '{default: '0};
      spr  <= '{default: '0};
      rs_q <= '0;
      rt_q <= '0;
    end else begin
      rs_q <= rd_fwd(bus.rs_addr);
      rt_q <= rd_fwd(bus.rt_addr);
      if (bus.wa_en && wa_dst != '0)      gpr[wa_dst]      <= wa_val;
      if (bus.wm_en && bus.wm_addr != '0) gpr[bus.wm_addr] <= bus.wm_data;
      if (bus.spr_we) spr[bus.spr_addr] <= spr_masked;
      // Later NBAs win per bit, so interrupt updates override only the bits they touch.
      if (bus.set_intr) begin
        if (!spr[STATUS][0]) begin
          spr[EPC]       <= bus.pc_in;
          spr[STATUS][1] <= spr[STATUS][0];
          spr[STATUS][0] <= 1'b1;
        end else begin
          spr[STATUS][2] <= 1'b1;
        end
      end else if (bus.eret) begin
        spr[STATUS][0] <= spr[STATUS][1];
        spr[STATUS][1] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mbscore_rf_bank.sv
// Scoreboard bench for mbscore_rf_bank: a GPR model pushes expected read data
// each cycle; the registered outputs are popped and compared one edge later.
module tb_mbscore_rf_bank;
  localparam int DW = 32, RAW = 5, SAW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mbscore_rf_bank_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .SPR_ADDR_WIDTH(SAW)) bus ();

  mbscore_rf_bank #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .SPR_ADDR_WIDTH(SAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [DW-1:0] rs; logic [DW-1:0] rt; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] m_gpr [32];
  int            checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.wa_en = 0; bus.wa_lui = 0; bus.wa_link = 0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wm_en = 0; bus.wm_addr = '0; bus.wm_data = '0;
    bus.spr_we = 0; bus.spr_wdata = '0; bus.spr_wmask = '0;
    bus.set_intr = 0; bus.eret = 0;
  endtask

  // Apply current inputs to the model, push expectations, clock, pop and compare.
  task automatic step(input string tag);
    exp_t          e;
    logic [RAW-1:0] a;
    logic [DW-1:0]  v;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      e.rs = '0; e.rt = '0;
    end else begin
      if (bus.wa_en) begin
        a = bus.wa_link ? 5'd31 : bus.wa_addr;
        v = bus.wa_link ? bus.pc_in + 32'd4 :
            bus.wa_lui  ? {bus.wa_data[15:0], 16'h0000} : bus.wa_data;
        if (a != 0) m_gpr[a] = v;
      end
      if (bus.wm_en && bus.wm_addr != 0) m_gpr[bus.wm_addr] = bus.wm_data;
      e.rs = m_gpr[bus.rs_addr];
      e.rt = m_gpr[bus.rt_addr];
    end
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, "_rs"}, bus.rs_out, e.rs);
    chk({tag, "_rt"}, bus.rt_out, e.rt);
    idle();
  endtask

  task automatic spr_chk(input string tag, input logic [SAW-1:0] a, input logic [DW-1:0] exp);
    bus.spr_addr = a; #1;
    chk(tag, bus.spr_out, exp);
  endtask

  initial begin
    rst = 1; idle();
    bus.rs_addr = 5'd5; bus.rt_addr = 5'd7; bus.pc_in = '0; bus.spr_addr = '0;
    bus.wa_en = 1; bus.wa_addr = 5'd5; bus.wa_data = 32'h1111;
    step("reset");
    chk("reset_int_en_n", {31'd0, bus.int_en_n}, 32'd0);
    spr_chk("reset_status", 3'd1, 32'd0);
    rst = 0;

    bus.rs_addr = 5'd5; step("first_read");
    chk("first_read_zero", bus.rs_out, 32'd0);

    bus.wa_en = 1; bus.wa_addr = 5'd5; bus.wa_data = 32'h12345678; bus.rs_addr = 5'd5;
    step("fwd_wa");
    chk("fwd_r5", bus.rs_out, 32'h12345678);

    bus.wa_en = 1; bus.wa_addr = 5'd7; bus.wa_data = 32'hAAAA0001;
    bus.wm_en = 1; bus.wm_addr = 5'd7; bus.wm_data = 32'h55550002; bus.rs_addr = 5'd7;
    step("wm_prio_fwd");
    chk("wm_prio_fwd_r7", bus.rs_out, 32'h55550002);
    bus.rt_addr = 5'd7; bus.rs_addr = 5'd5; step("wm_prio_stored");
    chk("wm_prio_stored_r7", bus.rt_out, 32'h55550002);

    bus.wa_en = 1; bus.wa_addr = 5'd3; bus.wa_data = 32'hCAFE0003;
    bus.wm_en = 1; bus.wm_addr = 5'd4; bus.wm_data = 32'hBEEF0004;
    bus.rs_addr = 5'd3; bus.rt_addr = 5'd4; step("dual_write");

    bus.wa_en = 1; bus.wa_lui = 1; bus.wa_addr = 5'd8; bus.wa_data = 32'h1234BEEF; bus.rs_addr = 5'd8;
    step("lui");
    chk("lui_r8", bus.rs_out, 32'hBEEF0000);

    bus.wa_en = 1; bus.wa_addr = 5'd31; bus.wa_data = 32'hDEAD; step("r31_pre");
    bus.wa_en = 1; bus.wa_link = 1; bus.wa_lui = 1; bus.wa_addr = 5'd9; bus.wa_data = 32'h7777;
    bus.pc_in = 32'hFFFFFFFC; bus.rs_addr = 5'd31; bus.rt_addr = 5'd9;
    step("link_wrap");
    chk("link_r31", bus.rs_out, 32'h0);

    bus.wa_en = 1; bus.wa_addr = 5'd0; bus.wa_data = 32'h99;
    bus.wm_en = 1; bus.wm_addr = 5'd0; bus.wm_data = 32'h98; bus.rs_addr = 5'd0;
    step("r0_write");
    chk("r0_zero", bus.rs_out, 32'h0);

    for (int i = 0; i < 40; i++) begin
      bus.wa_en = 1'($urandom); bus.wa_addr = 5'($urandom_range(0, 7)); bus.wa_data = $urandom;
      bus.wa_lui = ($urandom_range(0, 3) == 0); bus.wa_link = ($urandom_range(0, 7) == 0);
      bus.pc_in = $urandom;
      bus.wm_en = 1'($urandom); bus.wm_addr = 5'($urandom_range(0, 7)); bus.wm_data = $urandom;
      bus.rs_addr = 5'($urandom_range(0, 7));
      bus.rt_addr = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      step("rand");
    end

    bus.spr_we = 1; bus.spr_addr = 3'd2; bus.spr_wdata = 32'hFFFF0000; bus.spr_wmask = '1;
    step("spr_full");
    spr_chk("spr2_full", 3'd2, 32'hFFFF0000);
    bus.spr_we = 1; bus.spr_addr = 3'd2; bus.spr_wdata = 32'h0000FFFF; bus.spr_wmask = 32'h00FF00FF;
    step("spr_mask");
    spr_chk("spr2_mask", 3'd2, 32'hFF0000FF);

    bus.set_intr = 1; bus.pc_in = 32'h400; step("intr1");
    spr_chk("intr1_epc", 3'd0, 32'h400);
    chk("intr1_int_en_n", {31'd0, bus.int_en_n}, 32'd1);
    bus.set_intr = 1; bus.pc_in = 32'h800; step("intr2");
    spr_chk("intr2_epc", 3'd0, 32'h400);
    spr_chk("intr2_status", 3'd1, 32'h5);
    bus.eret = 1; step("eret1");
    chk("eret1_int_en_n", {31'd0, bus.int_en_n}, 32'd0);
    spr_chk("eret1_status", 3'd1, 32'h4);

    bus.set_intr = 1; bus.eret = 1; bus.pc_in = 32'h900; step("intr_eret");
    spr_chk("intr_eret_status", 3'd1, 32'h5);
    spr_chk("intr_eret_epc", 3'd0, 32'h900);
    bus.eret = 1; step("eret2");
    bus.spr_we = 1; bus.spr_addr = 3'd1; bus.spr_wdata = 32'h0; bus.spr_wmask = 32'h4;
    step("sticky_clr");
    spr_chk("sticky_clr_status", 3'd1, 32'h0);

    bus.spr_we = 1; bus.spr_addr = 3'd1; bus.spr_wdata = 32'hF0; bus.spr_wmask = 32'hFF;
    bus.set_intr = 1; bus.pc_in = 32'hA00; step("intr_over_spr");
    spr_chk("intr_over_spr_status", 3'd1, 32'hF1);
    bus.eret = 1; step("eret3");
    spr_chk("eret3_status", 3'd1, 32'hF0);

    bus.wa_en = 1; bus.wa_addr = 5'd5; bus.wa_data = 32'h5A5A; bus.set_intr = 1; bus.pc_in = 32'hB00;
    bus.rs_addr = 5'd5; bus.rt_addr = 5'd4;
    bus.set_intr = 1; step("pre_rst");
    rst = 1;
    bus.wa_en = 1; bus.wa_addr = 5'd6; bus.wa_data = 32'h6666; bus.set_intr = 1; bus.pc_in = 32'hC00;
    step("mid_rst");
    chk("mid_rst_rs", bus.rs_out, 32'h0);
    chk("mid_rst_int_en_n", {31'd0, bus.int_en_n}, 32'd0);
    spr_chk("mid_rst_status", 3'd1, 32'h0);
    spr_chk("mid_rst_epc", 3'd0, 32'h0);
    rst = 0;
    bus.rs_addr = 5'd5; bus.rt_addr = 5'd6; step("post_rst");
    chk("post_rst_r5", bus.rs_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
